// File: rtl/if_fetch_unit.sv
// Instruction-fetch requester: drives ROM ce/addr, buffers {pc, inst} in a small FIFO, hands entries to IF/ID.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise a sticky misalign_err.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        misalign_err
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
    } entry_t;

    entry_t             mem [BUF_DEPTH];
    logic [ADDR_W-1:0]  pc;
    logic               ce_q;
    logic               halted;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               pop;
    logic               capture;
    logic [ADDR_W-1:0]  load_pc;

    assign rom_addr = pc;
    assign rom_ce   = ce_q & ~halted;
    assign id_valid = (count != '0);
    assign pop      = id_valid & id_ready;
    assign capture  = rom_ce & ~redirect_en & ((count < CNT_W'(BUF_DEPTH)) | pop);

    // Head entry is read combinationally from registered storage; zeros when empty.
    always_comb begin
        id_pc   = '0;
        id_inst = '0;
        if (id_valid) begin
            id_pc   = mem[rd_ptr].pc;
            id_inst = mem[rd_ptr].inst;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign load_pc = redirect_target;

    // Misaligned redirect stops fetch until the next aligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redirect_en) begin
            halted       <= |redirect_target[1:0];
            misalign_err <= |redirect_target[1:0];
        end
    end
`else
    assign load_pc      = {redirect_target[ADDR_W-1:2], 2'b00};
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // PC, pointers and occupancy; redirect flushes everything and wins over capture/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ce_q   <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            ce_q <= 1'b1;
            if (redirect_en) begin
                pc     <= load_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (capture) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    pc     <= pc + ADDR_W'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(capture) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= '{pc: pc, inst: rom_inst};
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; ROM word at byte address a is a>>2.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_ce          (rom_ce),
        .rom_addr        (rom_addr),
        .rom_inst        (rom_inst),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    assign rom_inst = {2'b00, rom_addr[31:2]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc);
        check({tag, "_valid"}, 32'(id_valid), 32'd1);
        check({tag, "_pc"}, id_pc, exp_pc);
        check({tag, "_inst"}, id_inst, {2'b00, exp_pc[31:2]});
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect_en     = 1'b0;
        redirect_target = 32'h0;
        id_ready        = 1'b1;
        step();
        check("rst_ce", 32'(rom_ce), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_inst", id_inst, 32'd0);
        check("rst_err", 32'(misalign_err), 32'd0);
        check("rst_addr", rom_addr, 32'd0);

        // Release: ce rises after first edge, captures start on the second.
        rst_n = 1'b1;
        step();
        check("rel_ce", 32'(rom_ce), 32'd1);
        check("rel_valid", 32'(id_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_head("stream", 32'(4 * i));
        end

        // Stall: one more capture fills the FIFO, then PC holds at 0x14.
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("stall_head", id_pc, 32'h0C);
        check("stall_addr", rom_addr, 32'h14);
        check("stall_ce", 32'(rom_ce), 32'd1);
        id_ready = 1'b1;
        step();
        check_head("drain0", 32'h10);
        step();
        check_head("drain1", 32'h14);
        step();
        check_head("drain2", 32'h18);

        // Redirect while full.
        redirect_en = 1'b1; redirect_target = 32'h100; id_ready = 1'b0;
        step();
        check("rd1_valid", 32'(id_valid), 32'd0);
        check("rd1_addr", rom_addr, 32'h100);
        check("rd1_pc", id_pc, 32'd0);
        redirect_en = 1'b0; id_ready = 1'b1;
        step();
        check_head("rd1_t0", 32'h100);
        step();
        check_head("rd1_t1", 32'h104);

        // Fill, then redirect together with a pop, then a second redirect.
        id_ready = 1'b0;
        step();
        check("fill_addr", rom_addr, 32'h10C);
        id_ready = 1'b1; redirect_en = 1'b1; redirect_target = 32'h200;
        step();
        check("rd2_valid", 32'(id_valid), 32'd0);
        check("rd2_addr", rom_addr, 32'h200);
        redirect_target = 32'h300;
        step();
        check("rd3_valid", 32'(id_valid), 32'd0);
        check("rd3_addr", rom_addr, 32'h300);
        redirect_en = 1'b0;
        step();
        check_head("rd3_t0", 32'h300);
        step();
        check_head("rd3_t1", 32'h304);

        // Address wrap.
        redirect_en = 1'b1; redirect_target = 32'hFFFF_FFF8;
        step();
        check("wrap_valid", 32'(id_valid), 32'd0);
        redirect_en = 1'b0;
        step();
        check_head("wrap0", 32'hFFFF_FFF8);
        step();
        check_head("wrap1", 32'hFFFF_FFFC);
        step();
        check_head("wrap2", 32'h0);

        // Misaligned redirect.
        redirect_en = 1'b1; redirect_target = 32'h102;
        step();
        redirect_en = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_ce", 32'(rom_ce), 32'd0);
        check("mis_valid", 32'(id_valid), 32'd0);
        step();
        check("mis_err_hold", 32'(misalign_err), 32'd1);
        check("mis_ce_hold", 32'(rom_ce), 32'd0);
        check("mis_valid_hold", 32'(id_valid), 32'd0);
        redirect_en = 1'b1; redirect_target = 32'h200;
        step();
        redirect_en = 1'b0;
        check("rec_err", 32'(misalign_err), 32'd0);
        check("rec_ce", 32'(rom_ce), 32'd1);
        check("rec_valid", 32'(id_valid), 32'd0);
        step();
        check_head("rec_t0", 32'h200);
`else
        check("mis_addr", rom_addr, 32'h100);
        check("mis_err", 32'(misalign_err), 32'd0);
        step();
        check_head("mis_t0", 32'h100);
        check("mis_err2", 32'(misalign_err), 32'd0);
`endif

        // Mid-operation reset clears the buffer immediately.
        #1 rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(id_valid), 32'd0);
        check("mrst_ce", 32'(rom_ce), 32'd0);
        check("mrst_addr", rom_addr, 32'd0);
        check("mrst_pc", id_pc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch requester that drives the instruction ROM's `ce`/`addr` port and collects returned words for decode. Holds the program counter, captures the ROM's combinational `inst` output into a small FIFO tagged with its PC, and presents `{pc, inst}` to the IF/ID stage through a valid/ready handshake. Branch/jump redirects flush the buffer and restart fetch at the target address. Sits between the instruction ROM and the IF/ID register in the OpenMIPS pipeline.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `BUF_DEPTH`, 2, FIFO entries; power of two, 2..8
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rom_ce`  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`)
- `rom_addr`  out  `InstAddressBus` (32)  byte address presented to ROM; equals current PC
- `rom_inst`  in  `InstDataBus` (32)  ROM read data, valid in the same cycle as `rom_addr`
- `redirect_en`  in  1  branch/jump taken; one-cycle pulse
- `redirect_target`  in  32  new PC when `redirect_en`=1
- `id_valid`  out  1  head FIFO entry is valid
- `id_ready`  in  1  decode accepts head entry this cycle
- `id_pc`  out  32  PC of head entry
- `id_inst`  out  32  instruction of head entry
- `misalign_err`  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- State: `pc` (32), `ce_q` (1), FIFO storage `BUF_DEPTH` × 64, `rd_ptr`, `wr_ptr`, `count` (0..BUF_DEPTH), `halted` (1, macro only).
- `rom_addr` = `pc`; `rom_ce` = `ce_q` & ~`halted`.
- `pop` = `id_valid` & `id_ready`.
- `capture` = `rom_ce` & ~`redirect_en` & (`count` < BUF_DEPTH | `pop`).
- On `capture`: write `{pc, rom_inst}` at `wr_ptr`, `wr_ptr`++, `pc` <= `pc` + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
- `count` next = `count` + `capture` − `pop`; simultaneous capture and pop while full keeps `count` = BUF_DEPTH.
- Pointers wrap modulo BUF_DEPTH.
- `id_valid` = (`count` != 0). When empty: `id_pc` = 0, `id_inst` = `ZeroWord`; otherwise both come from the entry at `rd_ptr` (combinational read of registered storage).
- `redirect_en` has highest priority: `count`, `rd_ptr`, `wr_ptr` <= 0; `pc` <= `redirect_target`; no capture; a concurrent `pop` is honoured by decode but has no further effect (buffer cleared regardless).
- FIFO full and no pop: `pc` holds, `rom_addr` stable, `rom_ce` stays 1.

## Timing
- Reset (async assert): `pc`=RESET_PC, `ce_q`=0, `count`=0, pointers=0, `halted`=0, `misalign_err`=0; so `rom_ce`=0, `id_valid`=0, `id_pc`=0, `id_inst`=0.
- First rising edge after `rst_n` release sets `ce_q`=1; first capture on the following edge; `id_valid`=1 from then on. Reset mid-operation discards all buffered entries immediately.
- Steady state: one instruction per cycle when `id_ready` is held high.
- Capture-to-output latency: entry captured at edge N is visible on `id_*` after edge N (same cycle it becomes head).
- Redirect at edge N: `rom_addr`=target after edge N; target instruction captured at edge N+1; `id_valid`=1 with `id_pc`=target after edge N+1. `id_valid`=0 for the cycle between edges N and N+1.
- Back-to-back redirects: the later one wins; each restarts the sequence above.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with `redirect_target[1:0]` != 0 loads `pc`, sets `halted`=1 and `misalign_err`=1 (sticky). Fetch stops (`rom_ce`=0), buffer stays empty. The next aligned redirect clears `halted` and `misalign_err` and resumes normally.
- Undefined: `redirect_target[1:0]` is forced to 2'b00 when loaded; `halted` is not implemented; `misalign_err` is tied to 0.

## Test plan
- Reset release, `id_ready`=1, ROM word at index k = k -> `rom_ce` rises 1 cycle after release; `id_pc` sequence 0x0, 0x4, 0x8… with `id_inst` 0, 1, 2…, one per cycle, no gaps.
- `id_ready`=0 for 5 cycles -> FIFO fills to 2 entries, `rom_addr` holds at 0x8 (from PC 0); on release, entries 0x0 and 0x4 emitted in order, none dropped or duplicated.
- `redirect_en` pulse with target 0x100 while FIFO holds 2 entries -> `id_valid`=0 for 1 cycle, then `id_pc`=0x100, 0x104…; old entries never appear.
- Redirect in the same cycle as pop on a full FIFO, and two consecutive redirects (0x200 then 0x300) -> only the 0x300 stream appears.
- Redirect to 0xFFFF_FFF8 -> `id_pc` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap).
- Macro on: redirect to 0x102 -> `misalign_err`=1, `rom_ce`=0, `id_valid`=0; then redirect to 0x200 clears both flags and fetch resumes. Macro off: same stimulus -> `id_pc`=0x100, `misalign_err`=0.
